csr_irq_array: RTL

CSR_IRQ_ARRAY -- requirements
Module: csr_irq_array

---
 rtl/csr_pkg.sv | 25 ++
 rtl/csr_irq_prio.sv | 15 +
 rtl/csr_irq_array.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, trap cause codes, misa value, IRQ FSM states and the CSR read-modify-write helper
package csr_pkg;
   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [31:0] MISA_VAL       = 32'h4000_0100;
   localparam logic [4:0]  CAUSE_ILLEGAL  = 5'd2;
   localparam logic [4:0]  CAUSE_ECALL    = 5'd11;
   localparam logic [4:0]  CAUSE_IRQ_BASE = 5'd16;
   typedef enum logic {IDLE, REQ} irq_state_e;
   // op 01 = write, 10 = set bits, 11 = clear bits
   function automatic logic [31:0] csr_alu(input logic [1:0] op, input logic [31:0] rd, input logic [31:0] src);
      return op == 2'b01 ? src : op == 2'b10 ? (rd | src) : (rd & ~src);
   endfunction
endpackage

// File: rtl/csr_irq_prio.sv
// csr_irq_prio: lowest-index-wins priority encoder over the pending interrupt lines
module csr_irq_prio #(
   parameter int unsigned NUM_IRQ = 8
) (
   input  logic [NUM_IRQ-1:0] pend_i,
   output logic               valid,
   output logic [3:0]         idx
);
   assign valid = |pend_i;
   // scan downwards so the lowest set index is the last one assigned
   always_comb begin
      idx = 4'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) if (pend_i[i]) idx = 4'(i);
   end
endmodule

// File: rtl/csr_irq_array.sv
// csr_irq_array: machine-mode CSR file with local interrupt FSM and trap entry/return.
// Hardware counters mcycle/minstret are built only when CSR_COUNTERS_EN is defined.
module csr_irq_array
   import csr_pkg::*;
#(
   parameter int unsigned NUM_IRQ = 8,
   parameter int unsigned CNTR_W  = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_csr_ex,
   input  logic               cpu_stat_ex,
   input  logic [11:0]        csr_ofs_ex,
   input  logic [2:0]         csr_op2_ex,
   input  logic [4:0]         csr_uimm_ex,
   input  logic [31:0]        rs1_sel,
   output logic [31:0]        csr_rd_data,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic               trap_req,
   input  logic               trap_ack,
   output logic [29:0]        trap_vec,
   input  logic [29:0]        pc_excep,
   input  logic               cmd_ecall_ex,
   input  logic               illegal_ops_ex,
   input  logic [31:0]        illegal_ops_inst,
   input  logic               cmd_mret_ex,
   output logic [29:0]        csr_mepc_ex,
   output logic               csr_rmie,
   input  logic               retire_ex
);
   logic               mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
   logic [1:0]         mst_mpp_q, mst_mpp_d;
   logic [NUM_IRQ-1:0] irq_en_q, irq_en_d;
   logic [31:0]        mtvec_q, mtvec_d, mscratch_q, mscratch_d, mcause_q, mcause_d, mtval_q, mtval_d;
   logic [29:0]        mepc_q, mepc_d;
   irq_state_e         state_q, state_d;
   logic [3:0]         idx_q, idx_d, sel_idx;
   logic               sel_valid, we, exc, take, trap;
   logic [31:0]        src, wdata;
   logic [15:0]        en16_d;
   assign src   = csr_op2_ex[2] ? {27'b0, csr_uimm_ex} : rs1_sel;
   assign we    = cpu_stat_ex & cmd_csr_ex & (csr_op2_ex[1:0] != 2'b00);
   assign wdata = csr_alu(csr_op2_ex[1:0], csr_rd_data, src);
   assign exc   = illegal_ops_ex | cmd_ecall_ex;
   assign take  = (state_q == REQ) & trap_ack;
   assign trap  = exc | take;
   csr_irq_prio #(.NUM_IRQ(NUM_IRQ)) u_prio (
      .pend_i (irq_in & irq_en_q),
      .valid  (sel_valid),
      .idx    (sel_idx)
   );
`ifdef CSR_COUNTERS_EN
   logic [CNTR_W-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
   logic [63:0]       mcycle_x, minstret_x;
   assign mcycle_x   = 64'(mcycle_q);
   assign minstret_x = 64'(minstret_q);
   // a CSR write to either half replaces that cycle's increment
   always_comb begin
      mcycle_d   = we && csr_ofs_ex == CSR_MCYCLE ? {mcycle_q[CNTR_W-1:32], wdata} :
                   we && csr_ofs_ex == CSR_MCYCLEH ? {wdata[CNTR_W-33:0], mcycle_q[31:0]} :
                   mcycle_q + CNTR_W'(1);
      minstret_d = we && csr_ofs_ex == CSR_MINSTRET ? {minstret_q[CNTR_W-1:32], wdata} :
                   we && csr_ofs_ex == CSR_MINSTRETH ? {wdata[CNTR_W-33:0], minstret_q[31:0]} :
                   minstret_q + CNTR_W'(retire_ex);
   end
   // counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end
`else
   logic unused_cntr;
   assign unused_cntr = &{1'b0, retire_ex, CNTR_W[0]};
`endif
   // combinational CSR read mux; unimplemented addresses read zero
   always_comb begin
      case (csr_ofs_ex)
         CSR_MSTATUS:   csr_rd_data = {19'b0, mst_mpp_q, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
         CSR_MISA:      csr_rd_data = MISA_VAL;
         CSR_MIE:       csr_rd_data = 32'(irq_en_q) << 16;
         CSR_MTVEC:     csr_rd_data = mtvec_q;
         CSR_MSCRATCH:  csr_rd_data = mscratch_q;
         CSR_MEPC:      csr_rd_data = {mepc_q, 2'b00};
         CSR_MCAUSE:    csr_rd_data = mcause_q;
         CSR_MTVAL:     csr_rd_data = mtval_q;
         CSR_MIP:       csr_rd_data = 32'(irq_in) << 16;
`ifdef CSR_COUNTERS_EN
         CSR_MCYCLE:    csr_rd_data = mcycle_x[31:0];
         CSR_MCYCLEH:   csr_rd_data = mcycle_x[63:32];
         CSR_MINSTRET:  csr_rd_data = minstret_x[31:0];
         CSR_MINSTRETH: csr_rd_data = minstret_x[63:32];
`endif
         default:       csr_rd_data = 32'b0;
      endcase
   end
   // next CSR state: trap entry beats mret, and both beat a same-cycle CSR write
   always_comb begin
      mst_mie_d  = trap ? 1'b0 : cmd_mret_ex ? mst_mpie_q : we && csr_ofs_ex == CSR_MSTATUS ? wdata[3] : mst_mie_q;
      mst_mpie_d = trap ? mst_mie_q : cmd_mret_ex ? 1'b1 : we && csr_ofs_ex == CSR_MSTATUS ? wdata[7] : mst_mpie_q;
      mst_mpp_d  = trap | cmd_mret_ex ? 2'b11 : we && csr_ofs_ex == CSR_MSTATUS ? wdata[12:11] : mst_mpp_q;
      irq_en_d   = we && csr_ofs_ex == CSR_MIE ? wdata[16 +: NUM_IRQ] : irq_en_q;
      mtvec_d    = we && csr_ofs_ex == CSR_MTVEC ? wdata : mtvec_q;
      mscratch_d = we && csr_ofs_ex == CSR_MSCRATCH ? wdata : mscratch_q;
      mepc_d     = trap ? pc_excep : we && csr_ofs_ex == CSR_MEPC ? wdata[31:2] : mepc_q;
      mcause_d   = illegal_ops_ex ? 32'(CAUSE_ILLEGAL) : cmd_ecall_ex ? 32'(CAUSE_ECALL) :
                   take ? {1'b1, 26'b0, CAUSE_IRQ_BASE | {1'b0, idx_q}} :
                   we && csr_ofs_ex == CSR_MCAUSE ? wdata : mcause_q;
      mtval_d    = illegal_ops_ex ? illegal_ops_inst : trap ? 32'b0 : we && csr_ofs_ex == CSR_MTVAL ? wdata : mtval_q;
      en16_d     = 16'(irq_en_d);
   end
   // IRQ FSM: request while enabled; leave on exception, acknowledge, or enable being cleared
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (state_q == IDLE) begin
         if (mst_mie_q & sel_valid & mst_mie_d & en16_d[sel_idx]) begin
            state_d = REQ;
            idx_d   = sel_idx;
         end
      end else if (exc | trap_ack | !mst_mie_d | !en16_d[idx_q]) state_d = IDLE;
   end
   // CSR and FSM state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mst_mie_q  <= 1'b0;
         mst_mpie_q <= 1'b0;
         mst_mpp_q  <= 2'b00;
         irq_en_q   <= '0;
         mtvec_q    <= '0;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
         state_q    <= IDLE;
         idx_q      <= '0;
      end else begin
         mst_mie_q  <= mst_mie_d;
         mst_mpie_q <= mst_mpie_d;
         mst_mpp_q  <= mst_mpp_d;
         irq_en_q   <= irq_en_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
         state_q    <= state_d;
         idx_q      <= idx_d;
      end
   end
   assign trap_req    = state_q == REQ;
   assign csr_rmie    = mst_mie_q;
   assign csr_mepc_ex = mepc_q;
   assign trap_vec    = mtvec_q[1:0] == 2'b01 ?
                        mtvec_q[31:2] + (state_q == REQ ? {25'b0, 1'b1, idx_q} : 30'b0) : mtvec_q[31:2];
endmodule
